// File: rtl/video_chk_pkg.sv
// Shared types and constants for the video stream checker.
//   state_t  : checker state (SEARCH / MEASURE / LOCKED)
//   DEF_*    : default pixel data and geometry counter widths
//   CNT16_W  : width of the frame and pattern error counters
package video_chk_pkg;

   localparam int DEF_DATA_W = 10;
   localparam int DEF_CNT_W  = 12;
   localparam int CNT16_W    = 16;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

endpackage

// File: rtl/vid_pattern_chk.sv
// Walking-count data pattern checker. Expects 0 on the first active pixel
// of each line, then +1 per active pixel (mod 2^DATA_W).
//   clk, rstn  : pixel clock, async active-low reset
//   en         : checking enabled
//   de, data   : active-pixel qualifier and pixel data
//   line_start : first active pixel of a line
//   mismatch   : combinational pulse, pixel differs from the expected value
//   mis_cnt    : saturating count of mismatched pixels
module vid_pattern_chk
   import video_chk_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               en,
   input  logic               de,
   input  logic [DATA_W-1:0]  data,
   input  logic               line_start,
   output logic               mismatch,
   output logic [CNT16_W-1:0] mis_cnt
);

   logic [DATA_W-1:0]  exp_q, exp_d, exp_now;
   logic [CNT16_W-1:0] cnt_q, cnt_d;

   always_comb begin
      exp_now  = line_start ? '0 : exp_q;
      mismatch = en && de && (data != exp_now);
      exp_d    = de ? exp_now + 1'b1 : exp_q;
      cnt_d    = (mismatch && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         exp_q <= '0;
         cnt_q <= '0;
      end else begin
         exp_q <= exp_d;
         cnt_q <= cnt_d;
      end
   end

   assign mis_cnt = cnt_q;

endmodule

// File: rtl/video_stream_checker.sv
// Receive-side monitor for a de/hsync/vsync parallel video stream.
// Measures active geometry, locks to it and flags line-length, line-count
// and sync violations. Optional walking-count data check: PATTERN_CHECK_EN.
//   clk, rstn           : pixel clock, async active-low reset
//   de, hsync, vsync    : stream control; data valid when de=1
//   err_clr             : one-cycle pulse clearing the sticky error flags
//   locked              : geometry captured and enforced
//   meas_h, meas_v      : measured active pixels per line / lines per frame
//   frame_cnt           : completed frames since leaving SEARCH (saturating)
//   frame_done          : one-cycle pulse per completed frame
//   h_err, v_err        : sticky geometry violations while locked
//   sync_err            : sticky, de seen together with hsync or vsync
//   pat_err, pat_err_cnt: sticky pattern error and saturating pixel count
module video_stream_checker
   import video_chk_pkg::*;
#(
   parameter int DATA_W        = DEF_DATA_W,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int UNLOCK_FRAMES = 2
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               de,
   input  logic               hsync,
   input  logic               vsync,
   input  logic [DATA_W-1:0]  data,
   input  logic               err_clr,
   output logic               locked,
   output logic [CNT_W-1:0]   meas_h,
   output logic [CNT_W-1:0]   meas_v,
   output logic [CNT16_W-1:0] frame_cnt,
   output logic               frame_done,
   output logic               h_err,
   output logic               v_err,
   output logic               sync_err,
   output logic               pat_err,
   output logic [CNT16_W-1:0] pat_err_cnt
);

   logic              de_s1_q, de_s2_q, hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
   logic [DATA_W-1:0] data_s1_q, data_s2_q;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
   logic [CNT_W-1:0]   cand_h_q, cand_h_d, meas_h_q, meas_h_d, meas_v_q, meas_v_d;
   logic               cand_vld_q, cand_vld_d, meas_bad_q, meas_bad_d;
   logic               frame_bad_q, frame_bad_d;
   logic [3:0]         bad_cnt_q, bad_cnt_d;
   logic [CNT16_W-1:0] frame_cnt_q, frame_cnt_d;
   logic               frame_done_q, frame_done_d;
   logic               h_err_q, h_err_d, v_err_q, v_err_d, sync_err_q, sync_err_d;
   logic               pat_err_q, pat_err_d;

   logic               line_end, frame_end, line_start, pat_mis;
   logic [CNT_W-1:0]   line_cnt_eff, cand_now;
   logic               mbad_now, fbad_now, new_h, new_v, new_sync;
   logic               unused_sink;

   always_comb begin
      line_end   = de_s2_q && !de_s1_q;
      frame_end  = vs_s1_q && !vs_s2_q;
      line_start = de_s1_q && !de_s2_q;
      // A line closing in the same cycle as the frame belongs to that frame.
      line_cnt_eff = line_cnt_q;
      if (line_end && (line_cnt_q != '1)) line_cnt_eff = line_cnt_q + 1'b1;

      state_d      = state_q;
      pix_cnt_d    = pix_cnt_q;
      line_cnt_d   = frame_end ? '0 : line_cnt_eff;
      cand_h_d     = cand_h_q;
      cand_vld_d   = cand_vld_q;
      meas_bad_d   = meas_bad_q;
      meas_h_d     = meas_h_q;
      meas_v_d     = meas_v_q;
      frame_bad_d  = frame_bad_q;
      bad_cnt_d    = bad_cnt_q;
      frame_cnt_d  = frame_cnt_q;
      frame_done_d = 1'b0;
      cand_now     = cand_h_q;
      mbad_now     = meas_bad_q;
      fbad_now     = frame_bad_q;
      new_h        = 1'b0;
      new_v        = 1'b0;
      new_sync     = (state_q != SEARCH) && de_s1_q && (vs_s1_q || hs_s1_q);

      if (line_end)                          pix_cnt_d = '0;
      else if (de_s1_q && pix_cnt_q != '1)   pix_cnt_d = pix_cnt_q + 1'b1;

      case (state_q)
         SEARCH: begin
            if (frame_end) begin
               state_d     = MEASURE;
               pix_cnt_d   = '0;
               cand_vld_d  = 1'b0;
               meas_bad_d  = 1'b0;
               frame_bad_d = 1'b0;
               bad_cnt_d   = '0;
            end
         end
         MEASURE: begin
            if (line_end) begin
               if (!cand_vld_q) begin
                  cand_h_d   = pix_cnt_q;
                  cand_vld_d = 1'b1;
                  cand_now   = pix_cnt_q;
               end else if (pix_cnt_q != cand_h_q) begin
                  meas_bad_d = 1'b1;
                  mbad_now   = 1'b1;
               end
            end
            if (frame_end) begin
               if ((line_cnt_eff != '0) && !mbad_now) begin
                  meas_h_d    = cand_now;
                  meas_v_d    = line_cnt_eff;
                  state_d     = LOCKED;
                  bad_cnt_d   = '0;
                  frame_bad_d = 1'b0;
               end
               meas_bad_d = 1'b0;
               cand_vld_d = 1'b0;
            end
         end
         LOCKED: begin
            if (line_end && (pix_cnt_q != meas_h_q)) begin
               new_h       = 1'b1;
               fbad_now    = 1'b1;
               frame_bad_d = 1'b1;
            end
            if (frame_end) begin
               if (line_cnt_eff != meas_v_q) begin
                  new_v    = 1'b1;
                  fbad_now = 1'b1;
               end
               frame_bad_d = 1'b0;
               if (!fbad_now) begin
                  bad_cnt_d = '0;
               end else if ((bad_cnt_q + 4'd1) >= 4'(UNLOCK_FRAMES)) begin
                  state_d    = MEASURE;
                  bad_cnt_d  = '0;
                  cand_vld_d = 1'b0;
                  meas_bad_d = 1'b0;
               end else begin
                  bad_cnt_d = bad_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = SEARCH;
      endcase

      if (frame_end && (state_q != SEARCH)) begin
         frame_done_d = 1'b1;
         if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
      end

      // New errors take priority over a coincident clear.
      h_err_d    = (h_err_q && !err_clr) || new_h;
      v_err_d    = (v_err_q && !err_clr) || new_v;
      sync_err_d = (sync_err_q && !err_clr) || new_sync;
      pat_err_d  = (pat_err_q && !err_clr) || pat_mis;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         de_s1_q      <= 1'b0;
         de_s2_q      <= 1'b0;
         hs_s1_q      <= 1'b0;
         hs_s2_q      <= 1'b0;
         vs_s1_q      <= 1'b0;
         vs_s2_q      <= 1'b0;
         data_s1_q    <= '0;
         data_s2_q    <= '0;
         state_q      <= SEARCH;
         pix_cnt_q    <= '0;
         line_cnt_q   <= '0;
         cand_h_q     <= '0;
         cand_vld_q   <= 1'b0;
         meas_bad_q   <= 1'b0;
         meas_h_q     <= '0;
         meas_v_q     <= '0;
         frame_bad_q  <= 1'b0;
         bad_cnt_q    <= '0;
         frame_cnt_q  <= '0;
         frame_done_q <= 1'b0;
         h_err_q      <= 1'b0;
         v_err_q      <= 1'b0;
         sync_err_q   <= 1'b0;
         pat_err_q    <= 1'b0;
      end else begin
         de_s1_q      <= de;
         de_s2_q      <= de_s1_q;
         hs_s1_q      <= hsync;
         hs_s2_q      <= hs_s1_q;
         vs_s1_q      <= vsync;
         vs_s2_q      <= vs_s1_q;
         data_s1_q    <= data;
         data_s2_q    <= data_s1_q;
         state_q      <= state_d;
         pix_cnt_q    <= pix_cnt_d;
         line_cnt_q   <= line_cnt_d;
         cand_h_q     <= cand_h_d;
         cand_vld_q   <= cand_vld_d;
         meas_bad_q   <= meas_bad_d;
         meas_h_q     <= meas_h_d;
         meas_v_q     <= meas_v_d;
         frame_bad_q  <= frame_bad_d;
         bad_cnt_q    <= bad_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         frame_done_q <= frame_done_d;
         h_err_q      <= h_err_d;
         v_err_q      <= v_err_d;
         sync_err_q   <= sync_err_d;
         pat_err_q    <= pat_err_d;
      end
   end

`ifdef PATTERN_CHECK_EN
   vid_pattern_chk #(.DATA_W(DATA_W)) u_pat (
      .clk        (clk),
      .rstn       (rstn),
      .en         (state_q != SEARCH),
      .de         (de_s1_q),
      .data       (data_s1_q),
      .line_start (line_start),
      .mismatch   (pat_mis),
      .mis_cnt    (pat_err_cnt)
   );
   assign unused_sink = ^{hs_s2_q, data_s2_q};
`else
   assign pat_mis     = 1'b0;
   assign pat_err_cnt = '0;
   assign unused_sink = ^{hs_s2_q, data_s2_q, data_s1_q, line_start};
`endif

   assign locked     = (state_q == LOCKED);
   assign meas_h     = meas_h_q;
   assign meas_v     = meas_v_q;
   assign frame_cnt  = frame_cnt_q;
   assign frame_done = frame_done_q;
   assign h_err      = h_err_q;
   assign v_err      = v_err_q;
   assign sync_err   = sync_err_q;
   assign pat_err    = pat_err_q;

endmodule

// File: doc/video_stream_checker.md
Name: video_stream_checker

Overview:
Receive-side monitor for the camera-style parallel video stream (de/hsync/vsync/10-bit data) driven by the sim pattern source or the sensor path.
- Measures active geometry per line and per frame, locks to it, then flags line-length, line-count and sync violations.
- Optionally checks the walking-count data pattern.
- Sits on the pixel bus in sim benches and in the FPGA capture path as a hardware self-test.

Parameters:
DATA_W, 10, pixel data width
CNT_W, 12, width of pixel/line counters and measured geometry outputs
UNLOCK_FRAMES, 2, consecutive bad frames in LOCKED before re-measuring (1..15)

Ports:
clk  in  1  pixel clock
rstn  in  1  asynchronous active-low reset
de  in  1  active-pixel qualifier
hsync  in  1  line sync, active high
vsync  in  1  frame sync, active high
data  in  DATA_W  pixel data, valid when de=1
err_clr  in  1  one-cycle pulse, clears sticky error flags
locked  out  1  geometry captured and being enforced
meas_h  out  CNT_W  measured active pixels per line
meas_v  out  CNT_W  measured active lines per frame
frame_cnt  out  16  completed frames since leaving SEARCH, saturating
frame_done  out  1  one-cycle pulse per completed frame
h_err  out  1  sticky: line length differs from meas_h while LOCKED
v_err  out  1  sticky: line count differs from meas_v while LOCKED
sync_err  out  1  sticky: de=1 while vsync=1 or hsync=1
pat_err  out  1  sticky: data pattern mismatch (macro only)
pat_err_cnt  out  16  mismatched pixels, saturating (macro only)

Behaviour:
Reset and clocking
- Single clock domain: clk.
- Reset is asynchronous, active-low: rstn.
- In reset all outputs and counters are 0, state is SEARCH.
- Reset mid-frame discards partial measurements.

Input pipeline and events
- de, hsync, vsync and data are registered twice (s1, s2).
- Events are decoded from s1 vs s2:
  - line_end = de falling
  - frame_end = vsync rising
- Outputs update on the clock after the event is decoded. Input change at edge N appears on outputs at edge N+2.

Line counting
- pix_cnt counts de=1 cycles, saturating at all-ones.
- On line_end: line_len = pix_cnt, pix_cnt cleared, line_cnt++ (saturating).
- On frame_end: line_cnt cleared after use.

State SEARCH
- Ignore stream.
- frame_end -> MEASURE; counters cleared.

State MEASURE
- First line_end of the frame captures cand_h; a later line_end with a different length sets meas_bad.
- On frame_end:
  - If line_cnt>0 and !meas_bad: load meas_h=cand_h, meas_v=line_cnt, go to LOCKED, locked=1.
  - Otherwise stay in MEASURE and clear meas_bad.
- Every frame_end from MEASURE or LOCKED pulses frame_done and increments frame_cnt.

State LOCKED
- line_end with line_len != meas_h sets h_err and marks the frame bad.
- frame_end with line_cnt != meas_v sets v_err and marks the frame bad.
- Each bad frame increments bad_cnt; a good frame clears it.
- When bad_cnt reaches UNLOCK_FRAMES: locked=0, go to MEASURE, bad_cnt=0.
- meas_h and meas_v hold their last values until the next successful lock.

sync_err
- Set whenever s1 has de=1 together with vsync=1 or hsync=1, in any state except SEARCH.

Sticky flags and err_clr
- err_clr clears h_err, v_err, sync_err and pat_err.
- A new error in the same cycle as err_clr wins: the flag stays 1.
- err_clr does not affect the counters.

Simultaneous events
- line_end and frame_end in the same cycle: the line is processed first, so it is counted in the frame being closed.

Optional Feature:
PATTERN_CHECK_EN
- Defined:
  - Expected value is 0 on the first de=1 cycle of each line, then +1 per pixel, mod 2^DATA_W.
  - Mismatch sets pat_err and increments pat_err_cnt.
  - Active in MEASURE and LOCKED.
- Undefined: pat_err and pat_err_cnt are tied to 0 and no pattern logic is built.

Decomposition:
- Package video_chk_pkg holds:
  - state enum {SEARCH, MEASURE, LOCKED}
  - default CNT_W and DATA_W constants
  - 16-bit counter width constant
- One sub-module, vid_pattern_chk:
  - Inputs: de, data, line start.
  - Outputs: a mismatch pulse and a saturating count.
  - Instantiated only under PATTERN_CHECK_EN.

Test Plan:
1. Clean 640x400 walking-count stream, 3 frames -> first frame_end enters MEASURE; second sets locked=1, meas_h=640, meas_v=400, frame_cnt=1; third gives frame_cnt=2; all errors 0.
2. Locked, one line of 639 pixels -> h_err=1, locked stays 1; next frame good -> bad_cnt cleared, still locked.
3. Locked, two consecutive 399-line frames with UNLOCK_FRAMES=2 -> v_err=1, then locked=0 and state MEASURE; a clean frame after that re-locks with meas_v=400.
4. With PATTERN_CHECK_EN, data of pixel 5 on line 10 forced to 0x3FF -> pat_err=1, pat_err_cnt=1; same stimulus without the macro -> both 0.
5. de asserted one cycle inside vsync -> sync_err=1; err_clr coinciding with a second violation -> sync_err stays 1; err_clr alone later -> 0.
6. rstn low mid-frame while locked -> all outputs 0 asynchronously; after release, first vsync rise -> MEASURE, second -> locked=1.
